// File: rtl/xalu_muldiv.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, runs
// mult/multu/div/divu over a fixed cycle count and serves mfhi/mflo/mthi/mtlo.
module xalu_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  XALUop,
    input  logic        XALUstart,
    input  logic        XALUwe,
    input  logic        XALUhilo,
    input  logic        XALU_outsel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] out
);

    typedef enum logic [1:0] {
        OP_MULTU = 2'd0,
        OP_MULT  = 2'd1,
        OP_DIVU  = 2'd2,
        OP_DIV   = 2'd3
    } op_e;

    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    op_e         r_op;
    logic [3:0]  r_cnt;

    logic        w_done;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_is_signed_div;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_done = (r_cnt == 4'd1);

    // Sign- or zero-extending to 64 bits lets one 64-bit multiplier serve both
    // mult and multu; the low 64 bits of the product are exact either way.
    assign w_a_ext = (r_op == OP_MULT) ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
    assign w_b_ext = (r_op == OP_MULT) ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly
    // to 0x80000000 instead of overflowing.
    assign w_is_signed_div = (r_op == OP_DIV);
    assign w_a_neg    = w_is_signed_div & r_a[31];
    assign w_b_neg    = w_is_signed_div & r_b[31];
    assign w_a_mag    = w_a_neg ? -r_a : r_a;
    assign w_b_mag    = w_b_neg ? -r_b : r_b;
    assign w_div_zero = (r_b == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_rem      = w_a_neg ? -w_r_mag : w_r_mag;

    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULTU, OP_MULT: begin
                w_res_hi = w_prod[63:32];
                w_res_lo = w_prod[31:0];
            end
            OP_DIVU, OP_DIV: begin
                if (!w_div_zero) begin
                    w_res_hi = w_rem;
                    w_res_lo = w_quot;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_op  <= OP_MULTU;
            r_cnt <= 4'd0;
        end else if (r_cnt != 4'd0) begin
            // Running: start and HI/LO writes are contract violations, dropped.
            r_cnt <= r_cnt - 4'd1;
            if (w_done) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (XALUstart) begin
            r_a   <= A;
            r_b   <= B;
            r_op  <= op_e'(XALUop);
            r_cnt <= XALUop[1] ? LP_DIV_CNT : LP_MULT_CNT;
        end else if (XALUwe) begin
            if (XALUhilo) begin
                r_hi <= A;
            end else begin
                r_lo <= A;
            end
        end
    end

    assign busy      = (r_cnt != 4'd0);
    assign stall_req = busy | XALUstart;
    assign out       = XALU_outsel ? r_hi : r_lo;

endmodule
